// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath defaults, state encodings and helpers
package cnn_pkg;

    localparam int IN_D_W_DEF = 32;
    localparam int W_DEF      = 26;

    typedef enum logic {
        S_FILL   = 1'b0,
        S_REPEAT = 1'b1
    } up_state_t;

    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buf.sv
// rtl/line_buf.sv - single-row buffer, one write port and one combinational read port
module line_buf #(
    parameter int DW    = 32,
    parameter int DEPTH = 13,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // write port; contents are don't-care until written in the current row
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // asynchronous read so the replay value is available in the same cycle
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/upsample_2x.sv
// rtl/upsample_2x.sv - 2x nearest-neighbour upsampler with row replay buffer
module upsample_2x
    import cnn_pkg::*;
#(
    parameter int In_d_W = IN_D_W_DEF,
    parameter int W      = W_DEF
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [In_d_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [In_d_W-1:0] out_data,
    output logic                     out_last
);

    localparam int HALF = W / 2;
    localparam int CW   = ctr_width(HALF);
    localparam logic [CW-1:0] ICOL_LAST = CW'(HALF - 1);

    up_state_t state, state_n;
    logic             phase, phase_n;
    logic [CW-1:0]    icol, icol_n;
    logic             slot_free;
    logic             accept;
    logic             wr_en;
    logic             load;
    logic             load_last;
    logic [In_d_W-1:0] load_data;
    logic [In_d_W-1:0] rd_data;

    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    line_buf #(
        .DW    (In_d_W),
        .DEPTH (HALF),
        .AW    (CW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (icol),
        .wr_data (in_data),
        .rd_addr (icol),
        .rd_data (rd_data)
    );

    // state, counters and the registered output stage
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_FILL;
            phase     <= 1'b0;
            icol      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            icol  <= icol_n;
            if (slot_free) begin
                out_valid <= load;
                out_last  <= load_last;
                if (load) begin
                    out_data <= load_data;
                end
            end
        end
    end

    // next state: one input pixel yields two outputs, then the row is replayed
    always_comb begin
        state_n = state;
        phase_n = phase;
        icol_n  = icol;
        case (state)
            S_FILL: begin
                if (!phase) begin
                    if (accept) begin
                        phase_n = 1'b1;
                    end
                end else if (slot_free) begin
                    phase_n = 1'b0;
                    if (icol == ICOL_LAST) begin
                        icol_n  = '0;
                        state_n = S_REPEAT;
                    end else begin
                        icol_n = icol + CW'(1);
                    end
                end
            end
            S_REPEAT: begin
                if (slot_free) begin
                    phase_n = !phase;
                    if (phase) begin
                        if (icol == ICOL_LAST) begin
                            icol_n  = '0;
                            state_n = S_FILL;
                        end else begin
                            icol_n = icol + CW'(1);
                        end
                    end
                end
            end
            default: begin
                state_n = S_FILL;
            end
        endcase
    end

    // outputs: handshake, buffer write and output-register load selection
    always_comb begin
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        load      = 1'b0;
        load_last = 1'b0;
        load_data = rd_data;
        case (state)
            S_FILL: begin
                if (!phase) begin
                    in_ready  = slot_free && !clr;
                    wr_en     = accept;
                    load      = accept;
                    load_data = in_data;
                end else begin
                    load      = slot_free;
                    load_last = slot_free && (icol == ICOL_LAST);
                end
            end
            S_REPEAT: begin
                load      = slot_free;
                load_last = slot_free && phase && (icol == ICOL_LAST);
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_upsample_2x.sv
// tb/tb_upsample_2x.sv - randomized scoreboard bench for upsample_2x (W=4 and W=26)
module tb_upsample_2x;

    logic        clk;
    logic        clr;
    logic [1:0]  in_valid_v;
    logic [1:0]  out_ready_v;
    logic [1:0]  in_ready_v;
    logic [1:0]  out_valid_v;
    logic [1:0]  out_last_v;
    logic [31:0] in_data_a  [2];
    logic [31:0] out_data_a [2];

    int chk_cnt  = 0;
    int fail_cnt = 0;

    logic [31:0] src_q [$];
    logic [32:0] exp_q [$];

    upsample_2x #(.In_d_W(32), .W(4)) dut4 (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid_v[0]),
        .in_ready  (in_ready_v[0]),
        .in_data   (in_data_a[0]),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready_v[0]),
        .out_data  (out_data_a[0]),
        .out_last  (out_last_v[0])
    );

    upsample_2x #(.In_d_W(32), .W(26)) dut26 (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid_v[1]),
        .in_ready  (in_ready_v[1]),
        .in_data   (in_data_a[1]),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready_v[1]),
        .out_data  (out_data_a[1]),
        .out_last  (out_last_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // every complete row of h inputs becomes two output rows, each pixel doubled
    task automatic make_exp(input int h);
        int rows;
        rows = src_q.size() / h;
        for (int r = 0; r < rows; r++) begin
            for (int rep = 0; rep < 2; rep++) begin
                for (int c = 0; c < h; c++) begin
                    for (int k = 0; k < 2; k++) begin
                        exp_q.push_back({(c == h - 1) && (k == 1), src_q[r * h + c]});
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        clr         = 1'b1;
        in_valid_v  = 2'b11;
        out_ready_v = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_out_valid", 64'(out_valid_v[s]), 64'd0);
            check("rst_out_last",  64'(out_last_v[s]),  64'd0);
            check("rst_out_data",  64'(out_data_a[s]),  64'd0);
            check("rst_in_ready",  64'(in_ready_v[s]),  64'd0);
        end
        @(posedge clk); #1;
        clr        = 1'b0;
        in_valid_v = 2'b00;
    endtask

    // rmode: 0 ready always, 1 random ready, 2 ready low on cycles 1..3
    // vmode: 0 valid whenever data is pending, 1 random valid (held until taken)
    task automatic run(input int sel, input int h, input int rmode, input int vmode,
                       input int max_cyc, input bit must_finish);
        int cyc = 0;
        int n_acc = 0;
        int lasts = 0;
        int first_acc = -1;
        int first_out = -1;
        int last_out = -1;
        int n_out = 0;
        bit held = 1'b0;
        bit vhold = 1'b0;
        logic [31:0] held_d = '0;
        logic held_l = 1'b0;
        logic [32:0] e;
        logic iv, orr, ir, ov, ol;
        logic [31:0] od;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < max_cyc) begin
            if (src_q.size() > 0) begin
                iv = (vmode == 0) || vhold || ($urandom_range(0, 1) == 1);
                in_data_a[sel] = src_q[0];
            end else begin
                iv = 1'b0;
            end
            case (rmode)
                0:       orr = 1'b1;
                1:       orr = ($urandom_range(0, 3) != 0);
                default: orr = !(cyc >= 1 && cyc <= 3);
            endcase
            in_valid_v[sel]  = iv;
            out_ready_v[sel] = orr;
            @(negedge clk);
            ir = in_ready_v[sel];
            ov = out_valid_v[sel];
            ol = out_last_v[sel];
            od = out_data_a[sel];
            if (held) begin
                check("hold_valid", 64'(ov), 64'd1);
                check("hold_data",  64'(od), 64'(held_d));
                check("hold_last",  64'(ol), 64'(held_l));
            end
            if (ov && !orr) check("ready_blocked", 64'(ir), 64'd0);
            if (ov && orr) begin
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", 64'(od), 64'(e[31:0]));
                    check("last", 64'(ol), 64'(e[32]));
                    if (ol) lasts++;
                end
            end
            held   = ov && !orr;
            held_d = od;
            held_l = ol;
            if (iv && ir) begin
                if (first_acc < 0) first_acc = cyc;
                check("row_order", 64'(lasts >= 2 * (n_acc / h)), 64'd1);
                void'(src_q.pop_front());
                n_acc++;
                vhold = 1'b0;
            end else begin
                vhold = iv;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid_v[sel]  = 1'b0;
        out_ready_v[sel] = 1'b1;
        if (must_finish) begin
            check("done", 64'(src_q.size() + exp_q.size()), 64'd0);
            if (rmode == 0 && vmode == 0) begin
                check("gap_free", 64'(last_out - first_out + 1), 64'(n_out));
                check("latency",  64'(first_out), 64'(first_acc + 1));
            end
        end
        src_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] v;
        clr         = 1'b1;
        in_valid_v  = 2'b00;
        out_ready_v = 2'b11;
        in_data_a[0] = '0;
        in_data_a[1] = '0;

        do_reset();

        // basic W=4 pattern, full throughput
        src_q = '{32'd5, 32'hFFFF_FFFD, 32'd7, 32'd9};
        make_exp(2);
        run(0, 2, 0, 0, 100, 1'b1);

        // backpressure on the first output pixel (value 5)
        do_reset();
        src_q = '{32'd5, 32'd6, 32'd7, 32'd8};
        make_exp(2);
        run(0, 2, 2, 0, 200, 1'b1);

        // clear after one of two row-0 inputs, then a fresh row
        do_reset();
        src_q = '{32'd100};
        exp_q.push_back({1'b0, 32'd100});
        run(0, 2, 0, 0, 10, 1'b0);
        do_reset();
        src_q = '{32'd1, 32'd2};
        make_exp(2);
        run(0, 2, 0, 0, 100, 1'b1);

        // W=4, random ready and valid, several row pairs
        do_reset();
        for (int i = 0; i < 16; i++) src_q.push_back($urandom);
        make_exp(2);
        run(0, 2, 1, 1, 2000, 1'b1);

        // W=26, random data with extreme values, random handshakes
        do_reset();
        src_q.push_back(32'h8000_0000);
        src_q.push_back(32'h7FFF_FFFF);
        for (int i = 2; i < 78; i++) begin
            case ($urandom_range(0, 7))
                0:       v = 32'h8000_0000;
                1:       v = 32'h7FFF_FFFF;
                2:       v = 32'd0;
                default: v = $urandom;
            endcase
            src_q.push_back(v);
        end
        make_exp(13);
        run(1, 13, 1, 1, 8000, 1'b1);

        // W=26, full throughput
        for (int i = 0; i < 26; i++) src_q.push_back($urandom);
        make_exp(13);
        run(1, 13, 0, 0, 500, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/upsample_2x.md
UPSAMPLE_2X -- requirements
Module: upsample_2x

Interface
REQ-001 SHALL have parameter In_d_W, default 32: pixel width in bits (signed).
REQ-002 SHALL have parameter W, default 26: output row width; input row width is W/2; W SHALL be even and >= 4.
REQ-003 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port clr  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1: in_data carries a pooled pixel.
REQ-006 SHALL have port in_ready  output  1: block accepts in_data this cycle; combinational from state and out_ready.
REQ-007 SHALL have port in_data  input  In_d_W: signed pooled pixel, raster order, W/2 per row.
REQ-008 SHALL have port out_valid  output  1: out_data holds a valid upsampled pixel (registered).
REQ-009 SHALL have port out_ready  input  1: downstream consumes out_data this cycle.
REQ-010 SHALL have port out_data  output  In_d_W: signed upsampled pixel, registered.
REQ-011 SHALL have port out_last  output  1: registered; high with the last pixel (column W-1) of each output row.

Function
REQ-012 SHALL implement 2x nearest-neighbour upsampling: input pixel (r,c) appears at output (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1); values pass unmodified, no saturation or sign change.
REQ-013 SHALL define slot_free = !out_valid || out_ready; the output register loads only when slot_free, and otherwise holds out_data/out_valid/out_last unchanged.
REQ-014 SHALL use states S_FILL (first output row of a pair, fed from input) and S_REPEAT (second row, replayed from the row buffer), plus a 1-bit phase and an input-column counter icol in 0..W/2-1.
REQ-015 S_FILL, phase 0: in_ready = slot_free; on in_valid && in_ready, SHALL write in_data to row_buf[icol], load the output with in_data, and set phase to 1.
REQ-016 S_FILL, phase 1: in_ready = 0; when slot_free, SHALL load the output with row_buf[icol] and set phase to 0; on icol == W/2-1, SHALL set out_last, clear icol and enter S_REPEAT; otherwise SHALL increment icol.
REQ-017 S_REPEAT: in_ready = 0; when slot_free, SHALL load the output with row_buf[icol] and toggle phase; after phase 1, SHALL increment icol; on phase 1 with icol == W/2-1, SHALL set out_last, clear icol and return to S_FILL.
REQ-018 When slot_free and no new load occurs, SHALL clear out_valid and out_last.
REQ-019 Latency SHALL be 1 cycle from input acceptance to out_valid; with out_ready held high, output SHALL be gap-free, and input SHALL be accepted on every other cycle during S_FILL.
REQ-020 in_valid with in_ready low SHALL be ignored, with no state change; the source holds its data per valid/ready.
REQ-021 Back-to-back row pairs SHALL need no idle cycles: an S_REPEAT exit and the next S_FILL acceptance MAY occur on consecutive cycles.
REQ-022 row_buf SHALL NOT be read for a column before that column is written in the current S_FILL.

Reset
REQ-023 While clr is high: state = S_FILL, phase = 0, icol = 0, out_valid = 0, out_last = 0, out_data = 0, and in_ready SHALL be 0.
REQ-024 clr SHALL take priority over all activity; asserting it mid-row SHALL discard the partial row, and the first accepted pixel after release starts a new row at column 0.
REQ-025 row_buf contents need no reset.

Structure
REQ-026 In_d_W and W defaults, and the state encodings S_FILL/S_REPEAT, SHALL live in the shared CNN package used by pool_relu.
REQ-027 The row buffer SHALL be a sub-module line_buf (W/2 x In_d_W, 1 write + 1 read port, combinational read) to allow mapping to distributed RAM.

Verification
REQ-028 W=4, out_ready=1, inputs 5, -3 (row 0), 7, 9 (row 1) -> output 5,5,-3,-3 | 5,5,-3,-3 | 7,7,9,9 | 7,7,9,9; out_last on the 4th, 8th, 12th and 16th pixels.
REQ-029 Backpressure: out_ready low for 3 cycles while out_valid=1, value 5 -> out_data stays 5, in_ready=0, no pixel lost or duplicated.
REQ-030 in_valid high continuously during S_REPEAT -> in_ready=0 and no acceptance; the next row starts only after out_last of the repeat row.
REQ-031 clr pulsed after 1 of 2 row-0 inputs -> outputs cleared next cycle; new inputs 1, 2 yield 1,1,2,2,1,1,2,2.
REQ-032 W=26, random signed values including 0x80000000 and 0x7FFFFFFF, random out_ready -> scoreboard matches the 2x replication exactly.
